// File: rtl/gray_to_rgb_stream.sv
// Streaming grey-to-RGB expander: 2-entry skid buffer, raster eol/eof tagging.
// Define GRAY_FALSECOLOR_EN for heat-map colouring behind one extra pipeline register.
module gray_to_rgb_stream #(
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [23:0] out_pixel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_eol,
  output logic        out_eof
);

  localparam logic [11:0] XLast = 12'(H_RES - 1);
  localparam logic [11:0] YLast = 12'(V_RES - 1);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} occ_e;

  occ_e        occ_q, occ_d;
  logic [23:0] out_q, skid_q;
  logic        out_valid_q, in_ready_q;
  logic [11:0] x_q, y_q;
  logic        in_hs, out_hs;
  logic        buf_valid, buf_ready, buf_take;
  logic [23:0] buf_data;
  logic        full_d;

  assign in_hs     = in_valid & in_ready_q;
  assign out_hs    = out_valid_q & out_ready;
  assign buf_ready = (occ_q != StTwo);
  assign buf_take  = buf_valid & buf_ready;

`ifdef GRAY_FALSECOLOR_EN
  function automatic logic [7:0] sat8(input logic [9:0] v);
    return (v > 10'd255) ? 8'hFF : v[7:0];
  endfunction

  function automatic logic [23:0] heat(input logic [7:0] g);
    logic [9:0] t, r, gr, b;
    t  = 10'd0;
    r  = 10'd0;
    gr = 10'd0;
    b  = 10'd0;
    if (g < 8'd85) begin
      b = 10'd3 * {2'b00, g};
    end else if (g < 8'd170) begin
      t  = 10'd3 * ({2'b00, g} - 10'd85);
      gr = t;
      b  = 10'd255 - t;
    end else begin
      t  = 10'd3 * ({2'b00, g} - 10'd170);
      r  = t + 10'd3;
      gr = (t > 10'd255) ? 10'd0 : 10'd255 - t;
    end
    return {sat8(r), sat8(gr), sat8(b)};
  endfunction

  // Colour stage ahead of the skid buffer; it holds while the buffer is full.
  logic        p_valid_q, p_valid_d;
  logic [23:0] p_q;

  assign p_valid_d = in_hs | (p_valid_q & ~buf_ready);
  assign buf_valid = p_valid_q;
  assign buf_data  = p_q;
  assign full_d    = p_valid_d & (occ_d == StTwo);

  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid_q <= 1'b0;
      p_q       <= 24'h0;
    end else begin
      p_valid_q <= p_valid_d;
      if (in_hs) p_q <= heat(in_data);
    end
  end
`else
  assign buf_valid = in_hs;
  assign buf_data  = {3{in_data}};
  assign full_d    = (occ_d == StTwo);
`endif

  always_comb begin
    occ_d = occ_q;
    unique case (occ_q)
      StEmpty: if (buf_take) occ_d = StOne;
      StOne: begin
        if (buf_take && !out_hs) occ_d = StTwo;
        else if (!buf_take && out_hs) occ_d = StEmpty;
      end
      StTwo:   if (out_hs) occ_d = StOne;
      default: occ_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q       <= StEmpty;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_q       <= 24'h0;
      skid_q      <= 24'h0;
      x_q         <= 12'd0;
      y_q         <= 12'd0;
    end else begin
      occ_q       <= occ_d;
      out_valid_q <= (occ_d != StEmpty);
      in_ready_q  <= ~full_d;
      if (occ_q == StTwo) begin
        if (out_hs) out_q <= skid_q;
      end else if (buf_take) begin
        // Output register takes the sample if free or draining, otherwise it parks in skid.
        if (occ_q == StEmpty || out_hs) out_q <= buf_data;
        else skid_q <= buf_data;
      end
      if (out_hs) begin
        if (x_q == XLast) begin
          x_q <= 12'd0;
          y_q <= (y_q == YLast) ? 12'd0 : y_q + 12'd1;
        end else begin
          x_q <= x_q + 12'd1;
        end
      end
    end
  end

  assign out_pixel = out_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign out_eol   = out_valid_q & (x_q == XLast);
  assign out_eof   = out_valid_q & (x_q == XLast) & (y_q == YLast);

endmodule
